usb_tx: RTL and testbench
=========================

USB_TX -- requirements
Module: usb_tx

Interface
REQ-001 SHALL have port `clk`: input, 1 bit, single clock, 96 MHz (8 clocks per 12 Mb/s full-speed bit).
REQ-002 SHALL have port `rst`: input, 1 bit, synchronous, active-high reset.
REQ-003 SHALL have port `send_ack`: input, 1 bit, start pulse for an ACK handshake packet.
REQ-004 SHALL have port `send_nack`: input, 1 bit, start pulse for a NAK handshake packet.
REQ-005 SHALL have port `send_data`: input, 1 bit, start pulse for a DATA0 packet.
REQ-006 SHALL have port `tx_data`: input, 8 bits, next payload byte from the FIFO.
REQ-007 SHALL have port `fifo_empty`: input, 1 bit, high when no payload byte is available.
REQ-008 SHALL have port `get_data`: output, 1 bit, one-clock pulse when `tx_data` is latched.
REQ-009 SHALL have the following line and status outputs, each 1 bit:
- `d_plus`, `d_minus`: differential line outputs.
- `d_oe`: line drive enable.
- `tx_busy`: packet in progress.
- `tx_done`: one-clock pulse at packet end.

Function
REQ-010 SHALL sample start pulses only in IDLE, with priority ACK > NAK > DATA0 when several are asserted together.
REQ-011 SHALL ignore start pulses received while `tx_busy` is high.
REQ-012 SHALL use the FSM states IDLE, SYNC, PID, DATA, CRC1, CRC2, EOP_SE0, EOP_J, DONE.
REQ-013 SHALL follow these transitions:
- IDLE -> SYNC on start.
- SYNC -> PID.
- PID -> DATA for DATA0, PID -> EOP_SE0 for ACK/NAK.
- DATA -> CRC1 -> CRC2 -> EOP_SE0.
- EOP_SE0 -> EOP_J -> DONE -> IDLE.
REQ-014 SHALL drive the first bit period starting the clock after the start pulse, and hold every bit for exactly 8 clocks.
REQ-015 SHALL send all fields LSB first, as follows:
- SYNC 0x80, which appears on the wire as KJKJKJKK.
- PIDs: ACK 0xD2, NAK 0x5A, DATA0 0xC3.
REQ-016 SHALL NRZI-encode as follows:
- A 0 toggles the line between J (d_plus=1, d_minus=0) and K (d_plus=0, d_minus=1).
- A 1 holds the line.
- The line state before SYNC is J.
REQ-017 SHALL bit-stuff over PID, DATA and CRC fields:
- After six consecutive 1s, insert one 0 (a toggle).
- The run counter clears on any 0, stuffed or data.
- A stuffed bit adds 8 clocks and does not consume a data bit.
REQ-018 SHALL end each packet with EOP: SE0 (both lines 0) for 16 clocks, then J for 8 clocks.
REQ-019 SHALL, in DONE (one clock): pulse `tx_done`, and hold `d_oe` = 0 and `tx_busy` = 0.
REQ-020 SHALL hold `d_oe` and `tx_busy` high from the first SYNC clock through the last EOP_J clock.
REQ-021 SHALL, for an ACK/NAK with no stuffing, keep `d_oe` high for clocks 1..152 after the start pulse and assert `tx_done` on clock 153.
REQ-022 SHALL, on the clock ending the final bit period of PID or of a data byte:
- If `fifo_empty` = 0: pulse `get_data` and latch `tx_data`.
- Otherwise: advance to CRC1.
REQ-023 SHALL limit the payload to 64 bytes; after the 64th byte, advance to CRC1 regardless of `fifo_empty`.
REQ-024 SHALL allow a zero-length payload (`fifo_empty` high at end of PID).
REQ-025 SHALL compute CRC16 over the payload bytes only:
- Polynomial x^16+x^15+x^2+1, initial value 0xFFFF.
- Transmit the ones-complement, low byte first, LSB first.
REQ-026 SHALL hold idle values in IDLE: `d_plus` = 1, `d_minus` = 0, `d_oe` = 0.

Reset
REQ-027 SHALL, with `rst` high at a clock edge:
- Go to IDLE.
- Set `d_plus` = 1, `d_minus` = 0, `d_oe` = 0, `tx_busy` = 0, `tx_done` = 0, `get_data` = 0.
- Clear the stuff counter, byte counter and CRC register.
REQ-028 SHALL, when reset is asserted mid-packet, abort the packet with no EOP and no `tx_done`, and accept a start on the first clock after `rst` deasserts.

Configuration
REQ-029 SHALL, with `USB_TX_CRC16_EN` defined, generate and send CRC1/CRC2 internally per REQ-025.
REQ-030 SHALL, without `USB_TX_CRC16_EN`:
- Omit CRC1/CRC2 and the CRC register.
- Go DATA -> EOP_SE0.
- Treat the final two FIFO bytes as externally supplied CRC, with the byte limit raised to 66.

Verification
REQ-031 SHALL cover: `send_ack` pulse -> wire KJKJKJKK, NRZI(0xD2), SE0 for 16 clocks, J for 8 clocks; `tx_done` at clock 153; `get_data` never pulses.
REQ-032 SHALL cover: `send_data` with `fifo_empty` = 1 and macro on -> SYNC, NRZI(0xC3), bytes 0x00 0x00, EOP; `tx_done` at clock 281.
REQ-033 SHALL cover: `send_data` with a single byte 0xFF -> exactly one `get_data` pulse, and one stuffed 0 after payload bit 3 (run = PID's trailing two 1s plus four).
REQ-034 SHALL cover: `send_ack` and `send_data` asserted together -> only the ACK is sent, and a `send_nack` during `tx_busy` is ignored.
REQ-035 SHALL cover: FIFO holding 70 bytes -> exactly 64 `get_data` pulses, then CRC, then EOP.
REQ-036 SHALL cover: `rst` pulsed during DATA -> next clock `d_plus`/`d_minus`/`d_oe` = 1/0/0 with no `tx_done`; a following `send_nack` transmits a complete NAK packet.

Source files
------------

// File: rtl/usb_tx.sv
// Full-speed USB transmitter for ACK, NAK and DATA0 packets: SYNC, PID, payload, NRZI, bit stuffing, EOP.
// Optional feature: define USB_TX_CRC16_EN to generate the CRC16; otherwise the FIFO supplies the two CRC bytes.
module usb_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_ack,
    input  logic       send_nack,
    input  logic       send_data,
    input  logic [7:0] tx_data,
    input  logic       fifo_empty,
    output logic       get_data,
    output logic       d_plus,
    output logic       d_minus,
    output logic       d_oe,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SYNC    = 4'd1,
        PID     = 4'd2,
        DATA    = 4'd3,
        CRC1    = 4'd4,
        CRC2    = 4'd5,
        EOP_SE0 = 4'd6,
        EOP_J   = 4'd7,
        DONE    = 4'd8
    } state_t;

    localparam logic [7:0] SYNC_PAT  = 8'h80;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
`ifdef USB_TX_CRC16_EN
    localparam logic [6:0] MAX_BYTES = 7'd64;
`else
    localparam logic [6:0] MAX_BYTES = 7'd66;
`endif

    state_t     state_q;
    logic [2:0] clk_cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shreg_q;
    logic [7:0] pid_q;
    logic [2:0] ones_q;
    logic [6:0] byte_cnt_q;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc_q;

    // Reflected CRC16 (x^16+x^15+x^2+1) over one byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction
`endif

    logic       start_s;
    logic [7:0] start_pid_s;
    logic       end_bit_s;
    logic       stuff_s;
    logic       field_bit_s;
    state_t     field_state_s;
    logic [7:0] field_byte_s;
    logic       take_byte_s;
    logic       emit_bit_s;
    logic       line_next_s;

    // Start decode and the per-bit emission choice: stuffed 0, next bit of this field, or bit 0 of the next field.
    always_comb begin
        start_s     = send_ack | send_nack | send_data;
        start_pid_s = PID_DATA0;
        if (send_ack) begin
            start_pid_s = PID_ACK;
        end else if (send_nack) begin
            start_pid_s = PID_NAK;
        end else begin
            start_pid_s = PID_DATA0;
        end
        end_bit_s   = (clk_cnt_q == 3'd7);
        stuff_s     = (ones_q == 3'd6) &&
                      ((state_q == PID) || (state_q == DATA) || (state_q == CRC1) || (state_q == CRC2));
        field_bit_s = shreg_q[bit_idx_q + 3'd1];
        if (stuff_s) begin
            emit_bit_s = 1'b0;
        end else if (bit_idx_q != 3'd7) begin
            emit_bit_s = field_bit_s;
        end else begin
            emit_bit_s = field_byte_s[0];
        end
        line_next_s = emit_bit_s ? d_plus : ~d_plus;
    end

    // Field sequencing at the end of a field's last bit period.
    always_comb begin
        field_state_s = EOP_SE0;
        field_byte_s  = 8'h00;
        take_byte_s   = 1'b0;
        case (state_q)
            SYNC: begin
                field_state_s = PID;
                field_byte_s  = pid_q;
            end
            PID, DATA: begin
                if (((state_q == DATA) || (pid_q == PID_DATA0)) && !fifo_empty && (byte_cnt_q < MAX_BYTES)) begin
                    field_state_s = DATA;
                    field_byte_s  = tx_data;
                    take_byte_s   = 1'b1;
                end else if ((state_q == PID) && (pid_q != PID_DATA0)) begin
                    field_state_s = EOP_SE0;
                end else begin
`ifdef USB_TX_CRC16_EN
                    field_state_s = CRC1;
                    field_byte_s  = ~crc_q[7:0];
`else
                    field_state_s = EOP_SE0;
`endif
                end
            end
`ifdef USB_TX_CRC16_EN
            CRC1: begin
                field_state_s = CRC2;
                field_byte_s  = ~crc_q[15:8];
            end
`endif
            default: begin
                field_state_s = EOP_SE0;
                field_byte_s  = 8'h00;
            end
        endcase
    end

    // Packet FSM with registered line and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= 3'd0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'h00;
            pid_q      <= 8'h00;
            ones_q     <= 3'd0;
            byte_cnt_q <= 7'd0;
`ifdef USB_TX_CRC16_EN
            crc_q      <= 16'h0000;
`endif
            get_data   <= 1'b0;
            d_plus     <= 1'b1;
            d_minus    <= 1'b0;
            d_oe       <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            get_data  <= 1'b0;
            tx_done   <= 1'b0;
            clk_cnt_q <= clk_cnt_q + 3'd1;
            case (state_q)
                IDLE: begin
                    clk_cnt_q <= 3'd0;
                    if (start_s) begin
                        state_q    <= SYNC;
                        pid_q      <= start_pid_s;
                        shreg_q    <= SYNC_PAT;
                        bit_idx_q  <= 3'd0;
                        ones_q     <= 3'd0;
                        byte_cnt_q <= 7'd0;
`ifdef USB_TX_CRC16_EN
                        crc_q      <= 16'hFFFF;
`endif
                        // SYNC bit 0 is a 0, so the line leaves J for K.
                        d_plus     <= 1'b0;
                        d_minus    <= 1'b1;
                        d_oe       <= 1'b1;
                        tx_busy    <= 1'b1;
                    end else begin
                        d_plus     <= 1'b1;
                        d_minus    <= 1'b0;
                        d_oe       <= 1'b0;
                        tx_busy    <= 1'b0;
                    end
                end
                SYNC, PID, DATA, CRC1, CRC2: begin
                    if (end_bit_s) begin
                        d_plus  <= line_next_s;
                        d_minus <= ~line_next_s;
                        if ((state_q != SYNC) || (bit_idx_q == 3'd7)) begin
                            ones_q <= emit_bit_s ? (ones_q + 3'd1) : 3'd0;
                        end
                        if (!stuff_s && (bit_idx_q != 3'd7)) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end else if (!stuff_s) begin
                            bit_idx_q <= 3'd0;
                            state_q   <= field_state_s;
                            shreg_q   <= field_byte_s;
                            if (field_state_s == EOP_SE0) begin
                                d_plus  <= 1'b0;
                                d_minus <= 1'b0;
                            end
                            if (take_byte_s) begin
                                get_data   <= 1'b1;
                                byte_cnt_q <= byte_cnt_q + 7'd1;
`ifdef USB_TX_CRC16_EN
                                crc_q      <= crc16_byte(crc_q, tx_data);
`endif
                            end
                        end
                    end
                end
                EOP_SE0: begin
                    // SE0 spans two bit periods.
                    if (end_bit_s) begin
                        if (bit_idx_q == 3'd0) begin
                            bit_idx_q <= 3'd1;
                        end else begin
                            bit_idx_q <= 3'd0;
                            state_q   <= EOP_J;
                            d_plus    <= 1'b1;
                            d_minus   <= 1'b0;
                        end
                    end
                end
                EOP_J: begin
                    if (end_bit_s) begin
                        state_q <= DONE;
                        d_oe    <= 1'b0;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= 3'd0;
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= 3'd0;
                    d_plus    <= 1'b1;
                    d_minus   <= 1'b0;
                    d_oe      <= 1'b0;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: every clock of each packet is compared against a wire-level reference built per packet.
module tb_usb_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       send_ack;
    logic       send_nack;
    logic       send_data;
    logic [7:0] tx_data;
    logic       fifo_empty;
    logic       get_data;
    logic       d_plus;
    logic       d_minus;
    logic       d_oe;
    logic       tx_busy;
    logic       tx_done;

`ifdef USB_TX_CRC16_EN
    localparam bit CRC_ON = 1'b1;
    localparam int LIMIT  = 64;
`else
    localparam bit CRC_ON = 1'b0;
    localparam int LIMIT  = 66;
`endif

    // Line codes {d_oe, d_plus, d_minus}
    localparam logic [2:0] LN_J   = 3'b110;
    localparam logic [2:0] LN_K   = 3'b101;
    localparam logic [2:0] LN_SE0 = 3'b100;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] fifo_mem [0:127];
    int         fifo_cnt = 0;
    int         rd_ptr   = 0;
    logic [2:0] exp_q [$];
    logic       m_lvl;
    int         m_ones;

    always #5 clk = ~clk;

    usb_tx dut (
        .clk        (clk),
        .rst        (rst),
        .send_ack   (send_ack),
        .send_nack  (send_nack),
        .send_data  (send_data),
        .tx_data    (tx_data),
        .fifo_empty (fifo_empty),
        .get_data   (get_data),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .d_oe       (d_oe),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic fifo_drive();
        fifo_empty = (rd_ptr >= fifo_cnt);
        tx_data    = (rd_ptr < fifo_cnt) ? fifo_mem[rd_ptr] : 8'h00;
    endtask

    task automatic put_bit(input logic b);
        if (!b) m_lvl = ~m_lvl;
        exp_q.push_back(m_lvl ? LN_J : LN_K);
    endtask

    task automatic put_stuffed(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            put_bit(v[i]);
            if (v[i]) m_ones++;
            else m_ones = 0;
            if (m_ones == 6) begin
                put_bit(1'b0);
                m_ones = 0;
            end
        end
    endtask

    function automatic logic [15:0] ref_crc(input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ fifo_mem[i][j]) c = (c >> 1) ^ 16'hA001;
                else c = c >> 1;
            end
        end
        return c;
    endfunction

    task automatic build_expect(input logic [7:0] pid, input int npay, input bit with_crc);
        logic [7:0]  sync_v;
        logic [15:0] crc;
        exp_q.delete();
        m_lvl  = 1'b1;
        m_ones = 0;
        sync_v = 8'h80;
        for (int i = 0; i < 8; i++) put_bit(sync_v[i]);
        put_stuffed(pid);
        for (int i = 0; i < npay; i++) put_stuffed(fifo_mem[i]);
        if (with_crc) begin
            crc = ~ref_crc(npay);
            put_stuffed(crc[7:0]);
            put_stuffed(crc[15:8]);
        end
        exp_q.push_back(LN_SE0);
        exp_q.push_back(LN_SE0);
        exp_q.push_back(LN_J);
    endtask

    // Called at a falling edge; the start vector is sampled by the next rising edge (clock 0).
    task automatic run_packet(input string tag, input logic [2:0] starts, input logic [7:0] pid,
                              input int npay, input bit with_crc, input int hand_done,
                              input int exp_gets, input int nack_at);
        int done_at;
        int gets;
        int model_done;
        int want_done;
        done_at = 0;
        gets    = 0;
        build_expect(pid, npay, with_crc);
        model_done = 8 * exp_q.size() + 1;
        want_done  = (hand_done > 0) ? hand_done : model_done;
        rd_ptr = 0;
        fifo_drive();
        {send_ack, send_nack, send_data} = starts;
        @(negedge clk);
        {send_ack, send_nack, send_data} = 3'b000;
        for (int c = 1; c <= model_done + 16; c++) begin
            if (c == nack_at) send_nack = 1'b1;
            else send_nack = 1'b0;
            if (get_data) begin
                gets++;
                rd_ptr++;
                fifo_drive();
            end
            if (tx_done) begin
                done_at = c;
                break;
            end
            if (c < model_done)
                check($sformatf("%s line c%0d", tag, c),
                      {tx_done, tx_busy, d_oe, d_plus, d_minus}, {2'b01, exp_q[(c - 1) / 8]});
            @(negedge clk);
        end
        send_nack = 1'b0;
        check({tag, " done clock"}, done_at, want_done);
        check({tag, " done outputs"}, {tx_done, tx_busy, d_oe, d_plus, d_minus}, 5'b10010);
        check({tag, " get_data count"}, gets, exp_gets);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, " idle"}, {get_data, tx_done, tx_busy, d_oe, d_plus, d_minus}, 6'b000010);
        end
    endtask

    initial begin
        int gets;
        rst       = 1'b1;
        send_ack  = 1'b0;
        send_nack = 1'b0;
        send_data = 1'b0;
        fifo_cnt  = 0;
        rd_ptr    = 0;
        fifo_drive();
        repeat (3) @(negedge clk);
        check("reset outputs", {get_data, tx_done, tx_busy, d_oe, d_plus, d_minus}, 6'b000010);
        rst = 1'b0;
        @(negedge clk);
        check("idle after reset", {get_data, tx_done, tx_busy, d_oe, d_plus, d_minus}, 6'b000010);

        run_packet("ack", 3'b100, 8'hD2, 0, 1'b0, 153, 0, 0);

        fifo_cnt = 0;
        run_packet("data0 empty", 3'b001, 8'hC3, 0, CRC_ON, CRC_ON ? 281 : 153, 0, 0);

        fifo_mem[0] = 8'hFF;
        fifo_cnt    = 1;
        run_packet("data0 ff", 3'b001, 8'hC3, 1, CRC_ON, CRC_ON ? 361 : 225, 1, 0);

        fifo_mem[0] = 8'hA5;
        fifo_cnt    = 1;
        run_packet("ack+data prio", 3'b101, 8'hD2, 0, 1'b0, 153, 0, 20);

        for (int i = 0; i < 70; i++) fifo_mem[i] = 8'(i);
        fifo_cnt = 70;
        run_packet("long payload", 3'b001, 8'hC3, LIMIT, CRC_ON, 0, LIMIT, 0);

        // Abort a DATA0 packet in its payload with a one-clock reset.
        fifo_mem[0] = 8'h11;
        fifo_mem[1] = 8'h22;
        fifo_mem[2] = 8'h33;
        fifo_cnt    = 3;
        rd_ptr      = 0;
        fifo_drive();
        gets      = 0;
        send_data = 1'b1;
        @(negedge clk);
        send_data = 1'b0;
        for (int c = 1; c < 150; c++) begin
            if (get_data) begin
                gets++;
                rd_ptr++;
                fifo_drive();
            end
            @(negedge clk);
        end
        check("abort mid data busy", {tx_busy, d_oe}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        check("abort outputs", {get_data, tx_done, tx_busy, d_oe, d_plus, d_minus}, 6'b000010);
        check("abort get_data count", gets, 1);
        rst = 1'b0;
        run_packet("nak after rst", 3'b010, 8'h5A, 0, 1'b0, 153, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
